// File: rtl/simon_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simon_round_ctrl
// Description : Round sequencer for the Simon game datapath. Holds a loaded
//               colour pattern, replays the first `level` colours on the LEDs
//               with tick-timed on/off phases, then judges button entries one
//               by one. A full match grows the level; a mismatch or an input
//               timeout ends the game.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               tick       - timebase enable; all timers advance only when high
//               pat_load   - latch pat_data (IDLE/WIN/LOSE only)
//               pat_data   - colour i = pat_data[2i+1:2i]; 00 B 01 G 10 R 11 Y
//               start      - begin game at level 1 (IDLE/WIN/LOSE only)
//               btn_valid  - one-cycle pulse, player entry on btn_color
//               btn_color  - player colour, same encoding as the pattern
//               led        - one-hot colour display, B led[0] .. Y led[3]
//               phase      - state code (IDLE 0 .. LOSE 6)
//               level      - colours in current round, 0 before first start
//               win / lose - high while in WIN / LOSE
// Revision    : 1.0 - initial release
// ============================================================================
module simon_round_ctrl #(
    parameter int MAX_LEN       = 8,
    parameter int SHOW_TICKS    = 4,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic                           pat_load,
    input  logic [2*MAX_LEN-1:0]           pat_data,
    input  logic                           start,
    input  logic                           btn_valid,
    input  logic [1:0]                     btn_color,
    output logic [3:0]                     led,
    output logic [2:0]                     phase,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic                           win,
    output logic                           lose
);

    localparam int LVL_W  = $clog2(MAX_LEN + 1);
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int T_MAX0 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int T_MAX  = (T_MAX0 > TIMEOUT_TICKS) ? T_MAX0 : TIMEOUT_TICKS;
    localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0] C_SHOW_LAST = TMR_W'(SHOW_TICKS - 1);
    localparam logic [TMR_W-1:0] C_GAP_LAST  = TMR_W'(GAP_TICKS - 1);
    localparam logic [TMR_W-1:0] C_TO_LAST   = TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [LVL_W-1:0] C_MAX_LVL   = LVL_W'(MAX_LEN);
    localparam logic [LVL_W-1:0] C_LVL_ONE   = LVL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW_ON  = 3'd1,
        S_SHOW_OFF = 3'd2,
        S_INPUT    = 3'd3,
        S_ROUND_OK = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t               state_q,   state_d;
    logic [2*MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LVL_W-1:0]     level_q,   level_d;
    logic [IDX_W-1:0]     idx_q,     idx_d;
    logic [TMR_W-1:0]     timer_q,   timer_d;
    logic [3:0]           led_q,     led_d;
    logic                 win_q,     win_d;
    logic                 lose_q,    lose_d;

    logic [1:0]           cur_colour;
    logic [1:0]           next_colour;
    logic                 idx_last;

    // Colour the player is expected to enter / the one being replayed now.
    assign cur_colour = pattern_q[{idx_q, 1'b0} +: 2];
    // Last colour of the current round reached.
    assign idx_last   = (LVL_W'(idx_q) == (level_q - C_LVL_ONE));

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        level_d   = level_q;
        idx_d     = idx_q;
        timer_d   = timer_q;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (pat_load) begin
                    pattern_d = pat_data;
                end
                if (start) begin
                    state_d = S_SHOW_ON;
                    level_d = C_LVL_ONE;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end

            S_SHOW_ON: begin
                if (tick && (timer_q == C_SHOW_LAST)) begin
                    state_d = S_SHOW_OFF;
                    timer_d = '0;
                end else if (tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_SHOW_OFF: begin
                if (tick && (timer_q == C_GAP_LAST)) begin
                    timer_d = '0;
                    if (idx_last) begin
                        state_d = S_INPUT;
                        idx_d   = '0;
                    end else begin
                        state_d = S_SHOW_ON;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_INPUT: begin
                // A button entry takes priority over a coincident timeout.
                if (btn_valid) begin
                    timer_d = '0;
                    if (btn_color != cur_colour) begin
                        state_d = S_LOSE;
                    end else if (!idx_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (level_q == C_MAX_LVL) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_ROUND_OK;
                    end
                end else if (tick && (timer_q == C_TO_LAST)) begin
                    state_d = S_LOSE;
                    timer_d = '0;
                end else if (tick) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_ROUND_OK: begin
                state_d = S_SHOW_ON;
                level_d = level_q + C_LVL_ONE;
                idx_d   = '0;
                timer_d = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values and registered, so the
    // ports are plain flops with no path from any input.
    assign next_colour = pattern_d[{idx_d, 1'b0} +: 2];

    always_comb begin
        led_d  = 4'b0000;
        win_d  = 1'b0;
        lose_d = 1'b0;
        case (state_d)
            S_SHOW_ON: led_d  = 4'(4'b0001 << next_colour);
            S_WIN: begin
                led_d = 4'b1111;
                win_d = 1'b1;
            end
            S_LOSE:    lose_d = 1'b1;
            default:   led_d  = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            level_q   <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            led_q     <= 4'b0000;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            level_q   <= level_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            led_q     <= led_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign led   = led_q;
    assign phase = state_q;
    assign level = level_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule
`default_nettype wire
